// File: rtl/booth_mult_sequencer_if.sv
// Handshake and multiplier-bus bundle for booth_mult_sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface booth_mult_sequencer_if #(
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_product;
    logic           out_err;
    logic           busy;
    logic           mul_start;
    logic [W-1:0]   mul_data;
    logic           mul_done;
    logic [W-1:0]   mul_aout;
    logic [W-1:0]   mul_qout;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, mul_done, mul_aout, mul_qout,
        output in_ready, out_valid, out_product, out_err, busy, mul_start, mul_data
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, mul_done, mul_aout, mul_qout,
        input  in_ready, out_valid, out_product, out_err, busy, mul_start, mul_data
    );
endinterface

// File: rtl/booth_mult_sequencer.sv
// Feeds an operand pair into the Booth multiplier (start, M, Q on the shared bus),
// waits for done with a timeout, and holds the 2W-bit product for a downstream handshake.
module booth_mult_sequencer #(
    parameter int W       = 16,
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    booth_mult_sequencer_if.slave       bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] LOAD_M = 3'd2;
    localparam logic [2:0] LOAD_Q = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;
    localparam logic [2:0] HOLD   = 3'd5;

    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [2:0]     state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] product_q;
    logic           err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            product_q <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.in_a;
                        b_q   <= bus.in_b;
                        state <= START;
                    end
                end
                START:  state <= LOAD_M;
                LOAD_M: state <= LOAD_Q;
                LOAD_Q: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // done takes priority over a timeout landing on the same edge
                    if (bus.mul_done) begin
                        product_q <= {bus.mul_aout, bus.mul_qout};
                        err_q     <= 1'b0;
                        state     <= HOLD;
                    end else if (cnt == TO_LAST) begin
                        product_q <= '0;
                        err_q     <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        err_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [W-1:0] mul_data_d;

    always_comb begin
        mul_data_d = '0;
        case (state)
            LOAD_M:       mul_data_d = a_q;
            LOAD_Q, WAIT: mul_data_d = b_q;
            default:      mul_data_d = '0;
        endcase
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.mul_start   = (state == START);
    assign bus.mul_data    = mul_data_d;
    assign bus.out_valid   = (state == HOLD);
    assign bus.out_product = product_q;
    assign bus.out_err     = err_q;
endmodule

// File: doc/booth_mult_sequencer.md
Name: booth_mult_sequencer

Overview:
- Upstream and downstream wrapper around the Booth multiplier's data_path/control_path pair.
- Accepts an operand pair over a valid/ready handshake and drives the multiplier's start and shared data_in bus in the required load order.
- Waits for done, then captures {Aout,Qout} as a signed 2W-bit product and presents it over a valid/ready handshake.
- Flags a timeout if done never arrives.

Parameters:
- W, 16, operand width; matches the multiplier data_in width.
- TIMEOUT, 64, max cycles in WAIT before the error exit; must be greater than W+8.
- CW, 7, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  W  multiplicand (M), two's complement.
- in_b  in  W  multiplier (Q), two's complement.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_product  out  2W  signed product {Aout,Qout}.
- out_err  out  1  result is a timeout error; qualified by out_valid.
- busy  out  1  high in every state except IDLE.
- mul_start  out  1  to control_path start.
- mul_data  out  W  to shared data_in bus.
- mul_done  in  1  from control_path done.
- mul_aout  in  W  from data_path Aout.
- mul_qout  in  W  from data_path Qout.

Behaviour:
- Reset (async, rst_n=0), all values forced immediately:
  - state=IDLE; in_ready=1.
  - out_valid=0, out_err=0, out_product=0, busy=0.
  - mul_start=0, mul_data=0.
  - Operand registers 0, timeout counter 0.
- States: IDLE, START, LOAD_M, LOAD_Q, WAIT, HOLD. All outputs are registered or decoded from state; no combinational path from in_valid to outputs.
- IDLE:
  - in_ready=1.
  - Edge with in_valid=1: latch in_a and in_b, go to START.
- START (1 cycle):
  - mul_start=1, mul_data=0, in_ready=0.
  - Go to LOAD_M.
- LOAD_M (1 cycle):
  - mul_start=0, mul_data=latched a.
  - Go to LOAD_Q.
- LOAD_Q (1 cycle):
  - mul_data=latched b.
  - Go to WAIT, clearing the timeout counter.
- WAIT:
  - mul_data holds b.
  - Counter increments each cycle.
  - Edge where mul_done=1: capture out_product={mul_aout,mul_qout}, set out_err=0, go to HOLD.
  - Otherwise, when counter reaches TIMEOUT-1: set out_product=0, out_err=1, go to HOLD.
  - If mul_done arrives on the same edge as the timeout, done wins (out_err=0).
- HOLD:
  - out_valid=1; out_product and out_err stable until the handshake completes.
  - Edge with out_ready=1: out_valid→0, out_err→0, go to IDLE. in_ready is 1 in the following cycle; back-to-back acceptance has a one-cycle bubble.
  - out_ready held low: stay in HOLD indefinitely; mul_done pulses are ignored.
- mul_done sampled only in WAIT; done seen in any other state has no effect.
- Operand changes on in_a/in_b after the accept edge have no effect on the current operation.
- Latency: accept edge N → mul_start high in cycle N+1; M on the bus in N+2; Q in N+3; out_valid in the cycle after the done edge.
- Width rule: out_product = {mul_aout,mul_qout} taken verbatim. No sign correction; the multiplier's result is already two's complement 2W bits.
- Reset mid-operation (any state): immediate return to reset values. The multiplier is not reset by this block, so a stale done is ignored because state=IDLE.

Test Plan:
- Reset release, bench instantiates the real data_path/control_path. a=15, b=-10 → mul_data sequence 0, 15, 0xFFF6 on consecutive cycles after the accept; out_valid with out_product=0xFFFFFF6A (-150), out_err=0.
- a=-32768, b=-32768 → out_product=0x40000000. Then a=0, b=1234 → out_product=0. Consumer holds out_ready=1 throughout.
- Backpressure: out_ready=0 for 20 cycles after out_valid → out_product stable, in_ready=0, busy=1. Raise out_ready → IDLE next cycle, in_ready=1.
- Timeout: stub multiplier, mul_done tied 0 → out_valid rises exactly TIMEOUT cycles after entering WAIT; out_err=1, out_product=0.
- Done pulse injected during IDLE and HOLD → no state change. Done and timeout on the same edge → out_err=0, product captured.
- rst_n pulsed low in WAIT → outputs return to reset values without waiting for clk. Next pair 7×-3 → out_product=0xFFFFFFEB.
